// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: synchronizes the panel bus, rebuilds each shifted line and
// replays it as a column-ordered pixel write burst tagged with row and bitplane.
module hub75_rx_capture #(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 32,
    parameter int bpp_p    = 8,
    localparam int row_bits_p   = $clog2(vpixel_p / 2),
    localparam int plane_bits_p = $clog2(bpp_p),
    localparam int col_bits_p   = $clog2(hpixel_p),
    localparam int cnt_bits_p   = $clog2(hpixel_p + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_hclk,
    input  logic                    i_stb,
    input  logic [row_bits_p-1:0]   i_row,
    input  logic [5:0]              i_rgb,
    input  logic                    i_clr_overrun,
    output logic                    o_wr_en,
    output logic [row_bits_p-1:0]   o_wr_row,
    output logic [col_bits_p-1:0]   o_wr_col,
    output logic [plane_bits_p-1:0] o_wr_plane,
    output logic [5:0]              o_wr_rgb,
    output logic                    o_short_line,
    output logic                    o_overrun
);

    typedef enum logic {IDLE, EMIT} state_t;

    logic [2:0]            hclk_sync, stb_sync;
    logic [row_bits_p-1:0] row_s1, row_s2;
    logic [5:0]            rgb_s1, rgb_s2;
    logic                  hclk_rise, stb_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hclk_sync <= '0;
            stb_sync  <= '0;
            row_s1    <= '0;
            row_s2    <= '0;
            rgb_s1    <= '0;
            rgb_s2    <= '0;
        end else begin
            hclk_sync <= {hclk_sync[1:0], i_hclk};
            stb_sync  <= {stb_sync[1:0], i_stb};
            row_s1    <= i_row;
            row_s2    <= row_s1;
            rgb_s1    <= i_rgb;
            rgb_s2    <= rgb_s1;
        end
    end

    // Bit 2 is only an edge-detect delay; bit 1 is the synchronized level.
    assign hclk_rise = hclk_sync[1] & ~hclk_sync[2];
    assign stb_rise  = stb_sync[1] & ~stb_sync[2];

    logic [hpixel_p-1:0][5:0] shreg, shreg_nxt, hold;
    logic [cnt_bits_p-1:0]    cnt, cnt_shift;

    // New data enters at column 0 and pushes older pixels toward higher columns.
    always_comb begin
        shreg_nxt = shreg;
        if (hclk_rise)
            shreg_nxt = {shreg[hpixel_p-2:0], rgb_s2};
    end

    // Count including a shift that lands in the same cycle as the latch.
    assign cnt_shift = (hclk_rise && cnt != cnt_bits_p'(hpixel_p)) ? cnt + 1'b1 : cnt;

    state_t                state, state_nxt;
    logic [col_bits_p-1:0] col, col_nxt;
    logic                  accept;

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (stb_rise) begin
                    accept    = 1'b1;
                    state_nxt = EMIT;
                    col_nxt   = '0;
                end
            end
            EMIT: begin
                col_nxt = col + 1'b1;
                if (col == col_bits_p'(hpixel_p - 1)) begin
                    state_nxt = IDLE;
                    col_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [row_bits_p-1:0]   cur_row;
    logic [plane_bits_p-1:0] cur_plane;
    logic                    row_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            cnt          <= '0;
            cur_row      <= '0;
            cur_plane    <= '0;
            row_vld      <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_row     <= '0;
            o_wr_col     <= '0;
            o_wr_plane   <= '0;
            o_wr_rgb     <= '0;
            o_short_line <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            cnt   <= stb_rise ? '0 : cnt_shift;

            // row_vld stands in for an invalid previous row after reset.
            if (accept) begin
                cur_row <= row_s2;
                row_vld <= 1'b1;
                if (row_vld && row_s2 == cur_row)
                    cur_plane <= (cur_plane == plane_bits_p'(bpp_p - 1)) ? '0 : cur_plane + 1'b1;
                else
                    cur_plane <= '0;
            end

            o_wr_en <= (state == EMIT);
            if (state == EMIT) begin
                o_wr_col   <= col;
                o_wr_row   <= cur_row;
                o_wr_plane <= cur_plane;
                o_wr_rgb   <= hold[col];
            end

            o_short_line <= stb_rise && (cnt_shift < cnt_bits_p'(hpixel_p));

            if (stb_rise && state == EMIT)
                o_overrun <= 1'b1;
            else if (i_clr_overrun)
                o_overrun <= 1'b0;
        end
    end

    // Line storage carries no reset; it is always written before being read.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
        if (accept)
            hold <= shreg_nxt;
    end

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Bench for hub75_rx_capture: random panel lines driven on the async bus and
// compared against a queue-based line/plane model.
module tb_hub75_rx_capture;
    localparam int H = 64;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       i_hclk = 1'b0, i_stb = 1'b0, i_clr_overrun = 1'b0;
    logic [3:0] i_row = '0;
    logic [5:0] i_rgb = '0;
    logic       o_wr_en, o_short_line, o_overrun;
    logic [3:0] o_wr_row;
    logic [5:0] o_wr_col, o_wr_rgb;
    logic [2:0] o_wr_plane;

    hub75_rx_capture dut (
        .clk(clk), .rst_n(rst_n), .i_hclk(i_hclk), .i_stb(i_stb), .i_row(i_row),
        .i_rgb(i_rgb), .i_clr_overrun(i_clr_overrun), .o_wr_en(o_wr_en),
        .o_wr_row(o_wr_row), .o_wr_col(o_wr_col), .o_wr_plane(o_wr_plane),
        .o_wr_rgb(o_wr_rgb), .o_short_line(o_short_line), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Output monitor: logs every written pixel and burst boundaries
    logic [5:0] cap_col[$], cap_rgb[$];
    logic [3:0] cap_row[$];
    logic [2:0] cap_plane[$];
    int bursts = 0, run_len = 0, last_len = 0, first_cyc = -1, short_cnt = 0;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            if (!prev_en && first_cyc < 0) first_cyc = cyc;
            cap_col.push_back(o_wr_col);
            cap_rgb.push_back(o_wr_rgb);
            cap_row.push_back(o_wr_row);
            cap_plane.push_back(o_wr_plane);
            run_len++;
        end else if (prev_en) begin
            bursts++;
            last_len = run_len;
            run_len  = 0;
        end
        if (o_short_line === 1'b1) short_cnt++;
        prev_en = (o_wr_en === 1'b1);
    end

    // Reference model: line as a queue (front = column 0), plane bookkeeping
    logic [5:0] m_sr[$];
    int         m_cnt = 0, m_plane = 0;
    logic [3:0] m_row = '0;
    bit         m_vld = 0;
    logic [5:0] e_rgb[H];
    logic [3:0] e_row;
    logic [2:0] e_plane;
    bit         e_short;

    function automatic void m_shift(input logic [5:0] v);
        m_sr.push_front(v);
        void'(m_sr.pop_back());
        if (m_cnt < H) m_cnt++;
    endfunction

    function automatic void m_latch(input logic [3:0] r, input bit busy);
        e_short = (m_cnt < H);
        m_cnt   = 0;
        if (busy) return;
        m_plane = (m_vld && r == m_row) ? (m_plane + 1) % 8 : 0;
        m_row   = r;
        m_vld   = 1;
        for (int k = 0; k < H; k++) e_rgb[k] = m_sr[k];
        e_row   = r;
        e_plane = 3'(m_plane);
    endfunction

    task automatic shift_px(input logic [5:0] v);
        @(negedge clk); i_rgb = v;
        repeat (2) @(negedge clk); i_hclk = 1'b1;
        repeat (3) @(negedge clk); i_hclk = 1'b0;
        repeat (2) @(negedge clk);
        m_shift(v);
    endtask

    task automatic shift_rand(input int n);
        for (int k = 0; k < n; k++) shift_px(6'($urandom));
    endtask

    task automatic latch(input logic [3:0] r, input bit busy, output int c0);
        @(negedge clk); i_row = r;
        repeat (2) @(negedge clk); i_stb = 1'b1; c0 = cyc;
        repeat (3) @(negedge clk); i_stb = 1'b0;
        repeat (2) @(negedge clk);
        m_latch(r, busy);
    endtask

    task automatic clr_mon();
        cap_col.delete(); cap_rgb.delete(); cap_row.delete(); cap_plane.delete();
        bursts = 0; first_cyc = -1;
    endtask

    task automatic wait_bursts(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bursts >= n) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        m_cnt = 0; m_vld = 0; m_plane = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %b want 0", o_wr_en); end
        n_checks++; if (o_wr_row !== 4'd0) begin n_fail++; $display("FAIL rst_row got %h want 0", o_wr_row); end
        n_checks++; if (o_wr_col !== 6'd0) begin n_fail++; $display("FAIL rst_col got %h want 0", o_wr_col); end
        n_checks++; if (o_wr_plane !== 3'd0) begin n_fail++; $display("FAIL rst_plane got %h want 0", o_wr_plane); end
        n_checks++; if (o_wr_rgb !== 6'd0) begin n_fail++; $display("FAIL rst_rgb got %h want 0", o_wr_rgb); end
        n_checks++; if (o_short_line !== 1'b0) begin n_fail++; $display("FAIL rst_short got %b want 0", o_short_line); end
        n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b want 0", o_overrun); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_idle_wr_en got %b want 0", o_wr_en); end
    endtask

    task automatic test_basic();
        int c0, s0; bit ok;
        for (int k = 0; k < H; k++) m_sr.push_back('x);
        clr_mon(); s0 = short_cnt;
        for (int k = 0; k < H; k++) shift_px(6'(H - 1 - k));
        latch(4'd5, 1'b0, c0);
        wait_bursts(1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout bursts got %0d want 1", bursts); end
        n_checks++; if (last_len !== H) begin n_fail++; $display("FAIL basic_len got %0d want %0d", last_len, H); end
        n_checks++; if (first_cyc !== c0 + 4) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", first_cyc, c0 + 4); end
        for (int k = 0; k < cap_col.size(); k++) begin
            n_checks++;
            if (cap_col[k] !== 6'(k) || cap_rgb[k] !== 6'(k) || cap_row[k] !== 4'd5 || cap_plane[k] !== 3'd0) begin
                n_fail++;
                $display("FAIL basic_pix idx %0d got col %0d rgb %h row %0d plane %0d want col %0d rgb %h row 5 plane 0",
                         k, cap_col[k], cap_rgb[k], cap_row[k], cap_plane[k], k, 6'(k));
            end
        end
        n_checks++; if (short_cnt - s0 !== 0) begin n_fail++; $display("FAIL basic_short got %0d want 0", short_cnt - s0); end
        n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun got %b want 0", o_overrun); end
    endtask

    task automatic test_planes();
        int c0, s0; bit ok;
        logic [3:0] r;
        do_reset();
        s0 = short_cnt;
        for (int i = 0; i < 10; i++) begin
            r = (i < 9) ? 4'd5 : 4'd6;
            shift_rand(H);
            clr_mon();
            latch(r, 1'b0, c0);
            wait_bursts(1, ok);
            n_checks++; if (!ok || last_len !== H) begin n_fail++; $display("FAIL planes_len line %0d got %0d want %0d", i, last_len, H); end
            n_checks++; if (e_plane !== ((i < 8) ? 3'(i) : 3'd0)) begin n_fail++; $display("FAIL planes_model line %0d got %0d", i, e_plane); end
            for (int k = 0; k < cap_col.size(); k++) begin
                n_checks++;
                if (cap_col[k] !== 6'(k) || cap_rgb[k] !== e_rgb[k] || cap_row[k] !== e_row || cap_plane[k] !== e_plane) begin
                    n_fail++;
                    $display("FAIL planes_pix line %0d idx %0d got col %0d rgb %h row %0d plane %0d want rgb %h row %0d plane %0d",
                             i, k, cap_col[k], cap_rgb[k], cap_row[k], cap_plane[k], e_rgb[k], e_row, e_plane);
                end
            end
        end
        n_checks++; if (short_cnt - s0 !== 0) begin n_fail++; $display("FAIL planes_short got %0d want 0", short_cnt - s0); end
    endtask

    task automatic test_short();
        int c0, s0; bit ok;
        s0 = short_cnt;
        shift_rand(40);
        clr_mon();
        latch(4'($urandom), 1'b0, c0);
        wait_bursts(1, ok);
        n_checks++; if (!ok || last_len !== H) begin n_fail++; $display("FAIL short_len got %0d want %0d", last_len, H); end
        n_checks++; if (short_cnt - s0 !== 1) begin n_fail++; $display("FAIL short_pulse got %0d want 1", short_cnt - s0); end
        for (int k = 0; k < cap_col.size(); k++) begin
            n_checks++;
            if (cap_col[k] !== 6'(k) || cap_rgb[k] !== e_rgb[k] || cap_row[k] !== e_row || cap_plane[k] !== e_plane) begin
                n_fail++;
                $display("FAIL short_pix idx %0d got rgb %h row %0d plane %0d want rgb %h row %0d plane %0d",
                         k, cap_rgb[k], cap_row[k], cap_plane[k], e_rgb[k], e_row, e_plane);
            end
        end
    endtask

    task automatic test_overrun();
        int c0, c1, s0; bit ok;
        logic [3:0] r1, r2;
        logic [2:0] p0;
        r1 = 4'($urandom); r2 = r1 ^ 4'h3;
        shift_rand(H);
        clr_mon(); s0 = short_cnt;
        latch(r1, 1'b0, c0);
        repeat (6) @(negedge clk);
        n_checks++; if (o_wr_en !== 1'b1) begin n_fail++; $display("FAIL overrun_inburst got %b want 1", o_wr_en); end
        latch(r2, 1'b1, c1);
        wait_bursts(1, ok);
        n_checks++; if (!ok || last_len !== H) begin n_fail++; $display("FAIL overrun_len got %0d want %0d", last_len, H); end
        for (int k = 0; k < cap_col.size(); k++) begin
            n_checks++;
            if (cap_col[k] !== 6'(k) || cap_rgb[k] !== e_rgb[k] || cap_row[k] !== r1 || cap_plane[k] !== e_plane) begin
                n_fail++;
                $display("FAIL overrun_pix idx %0d got rgb %h row %0d plane %0d want rgb %h row %0d plane %0d",
                         k, cap_rgb[k], cap_row[k], cap_plane[k], e_rgb[k], r1, e_plane);
            end
        end
        n_checks++; if (o_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag got %b want 1", o_overrun); end
        n_checks++; if (short_cnt - s0 !== 1) begin n_fail++; $display("FAIL overrun_short got %0d want 1", short_cnt - s0); end
        @(negedge clk); i_clr_overrun = 1'b1;
        @(negedge clk); i_clr_overrun = 1'b0;
        n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got %b want 0", o_overrun); end
        p0 = e_plane;
        shift_rand(H);
        clr_mon();
        latch(r1, 1'b0, c0);
        wait_bursts(1, ok);
        n_checks++;
        if (!ok || cap_plane.size() == 0 || cap_plane[0] !== e_plane || e_plane !== 3'((p0 + 1) % 8) || cap_row[0] !== r1) begin
            n_fail++;
            $display("FAIL overrun_next_plane got %0d want %0d", (cap_plane.size() > 0) ? cap_plane[0] : 3'd0, 3'((p0 + 1) % 8));
        end
    endtask

    task automatic test_same_cycle();
        int c0, s0; bit ok;
        logic [5:0] v;
        logic [3:0] r;
        shift_rand(H - 1);
        v = 6'($urandom); r = 4'($urandom);
        clr_mon(); s0 = short_cnt;
        @(negedge clk); i_rgb = v; i_row = r;
        repeat (2) @(negedge clk); i_hclk = 1'b1; i_stb = 1'b1;
        repeat (3) @(negedge clk); i_hclk = 1'b0; i_stb = 1'b0;
        repeat (2) @(negedge clk);
        m_shift(v);
        m_latch(r, 1'b0);
        wait_bursts(1, ok);
        n_checks++; if (!ok || last_len !== H) begin n_fail++; $display("FAIL same_len got %0d want %0d", last_len, H); end
        n_checks++; if (cap_rgb.size() == 0 || cap_rgb[0] !== v) begin n_fail++; $display("FAIL same_col0 got %h want %h", (cap_rgb.size() > 0) ? cap_rgb[0] : 6'h0, v); end
        for (int k = 0; k < cap_col.size(); k++) begin
            n_checks++;
            if (cap_col[k] !== 6'(k) || cap_rgb[k] !== e_rgb[k] || cap_row[k] !== e_row || cap_plane[k] !== e_plane) begin
                n_fail++;
                $display("FAIL same_pix idx %0d got rgb %h row %0d plane %0d want rgb %h row %0d plane %0d",
                         k, cap_rgb[k], cap_row[k], cap_plane[k], e_rgb[k], e_row, e_plane);
            end
        end
        n_checks++; if (short_cnt - s0 !== 0) begin n_fail++; $display("FAIL same_short got %0d want 0", short_cnt - s0); end
        // A count left at 1 would make 63 more shifts look like a full line.
        shift_rand(H - 1);
        clr_mon(); s0 = short_cnt;
        latch(r, 1'b0, c0);
        wait_bursts(1, ok);
        n_checks++; if (short_cnt - s0 !== 1) begin n_fail++; $display("FAIL same_next_count short got %0d want 1", short_cnt - s0); end
    endtask

    task automatic test_reset_mid();
        int c0; bit ok;
        logic [3:0] r;
        r = 4'($urandom);
        shift_rand(H);
        latch(r, 1'b0, c0);
        latch(r, 1'b0, c0);
        for (int i = 0; i < 100 && o_wr_en !== 1'b1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_checks++; if (o_wr_en !== 1'b1) begin n_fail++; $display("FAIL rmid_inburst got %b want 1", o_wr_en); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_abort got %b want 0", o_wr_en); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0; m_vld = 0; m_plane = 0;
        @(negedge clk);
        clr_mon();
        repeat (20) @(negedge clk);
        n_checks++; if (cap_col.size() !== 0) begin n_fail++; $display("FAIL rmid_partial got %0d writes want 0", cap_col.size()); end
        shift_rand(H);
        clr_mon();
        latch(r, 1'b0, c0);
        wait_bursts(1, ok);
        n_checks++;
        if (!ok || cap_plane.size() == 0 || cap_plane[0] !== 3'd0 || cap_row[0] !== r) begin
            n_fail++;
            $display("FAIL rmid_plane got %0d want 0", (cap_plane.size() > 0) ? cap_plane[0] : 3'd7);
        end
        for (int k = 0; k < cap_col.size(); k++) begin
            n_checks++;
            if (cap_rgb[k] !== e_rgb[k]) begin
                n_fail++;
                $display("FAIL rmid_pix idx %0d got rgb %h want %h", k, cap_rgb[k], e_rgb[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_planes();
        test_short();
        test_overrun();
        test_same_cycle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
